// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: turns debounced 4x4 keypad codes into a multi-digit number for display and MMIO.
// Optional decimal entry with binary conversion is enabled by defining KEYPAD_DECIMAL_EN.
module keypad_entry_buffer #(
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  key_coord,
    output logic [31:0] disp_value,
    output logic [3:0]  disp_digits,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        key_err
);

    localparam logic [3:0]  K_STAR   = 4'hE;
    localparam logic [3:0]  K_ENTER  = 4'hF;
    localparam logic [3:0]  MAX_CNT  = 4'(MAX_DIGITS);
    localparam logic [31:0] BUF_MASK = 32'((64'd1 << (4 * MAX_DIGITS)) - 64'd1);
`ifdef KEYPAD_DECIMAL_EN
    localparam logic [3:0]  LAST_DIGIT = 4'd9;
`else
    localparam logic [3:0]  LAST_DIGIT = 4'hD;
`endif

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
`ifdef KEYPAD_DECIMAL_EN
        S_CONVERT = 2'd1,
`endif
        S_HOLD    = 2'd2
    } state_t;

    // {valid, line index}: a line is valid when exactly one bit is low
    function automatic logic [2:0] dec_line(input logic [3:0] n);
        case (n)
            4'h7:    dec_line = 3'b100;
            4'hB:    dec_line = 3'b101;
            4'hD:    dec_line = 3'b110;
            4'hE:    dec_line = 3'b111;
            default: dec_line = 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [3:0] pos);
        case (pos)
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = K_STAR;
            4'd13:   key_map = 4'h0;
            4'd14:   key_map = K_ENTER;
            default: key_map = 4'hD;
        endcase
    endfunction

    state_t      r_state, w_state_n;
    logic [7:0]  r_prev, r_code;
    logic        r_evt;
    logic [31:0] r_buf, w_buf_n;
    logic [3:0]  r_cnt, w_cnt_n;
    logic [31:0] r_dout, w_dout_n;
    logic        r_dv, w_dv_n;
    logic        r_err, w_err_n;
    logic [2:0]  w_row, w_col;
    logic        w_valid, w_event;
    logic [3:0]  w_key;
`ifdef KEYPAD_DECIMAL_EN
    logic [31:0] r_acc, w_acc_n, w_acc_mac;
    logic [2:0]  r_idx, w_idx_n;
    logic [3:0]  w_nib;
`endif

    assign w_event = (key_coord != 8'h00) && (r_prev == 8'h00);
    assign w_row   = dec_line(r_code[7:4]);
    assign w_col   = dec_line(r_code[3:0]);
    assign w_valid = w_row[2] & w_col[2];
    assign w_key   = key_map({w_row[1:0], w_col[1:0]});
`ifdef KEYPAD_DECIMAL_EN
    assign w_nib     = r_buf[{r_idx, 2'b00} +: 4];
    assign w_acc_mac = (r_acc * 32'd10) + {28'd0, w_nib};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_ENTRY;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_buf_n   = r_buf;
        w_cnt_n   = r_cnt;
        w_dout_n  = r_dout;
        w_dv_n    = r_dv;
        w_err_n   = 1'b0;
`ifdef KEYPAD_DECIMAL_EN
        w_acc_n   = r_acc;
        w_idx_n   = r_idx;
`endif
        case (r_state)
            S_ENTRY: begin
                if (r_evt) begin
                    if (!w_valid) begin
                        w_err_n = 1'b1;
                    end else if (w_key == K_STAR) begin
                        if (r_cnt != 4'd0) begin
                            w_buf_n = r_buf >> 4;
                            w_cnt_n = r_cnt - 4'd1;
                        end
                    end else if (w_key == K_ENTER) begin
                        if (r_cnt != 4'd0) begin
`ifdef KEYPAD_DECIMAL_EN
                            w_acc_n   = 32'd0;
                            w_idx_n   = 3'(r_cnt - 4'd1);
                            w_state_n = S_CONVERT;
`else
                            w_dout_n  = r_buf;
                            w_dv_n    = 1'b1;
                            w_state_n = S_HOLD;
`endif
                        end
                    end else if (w_key > LAST_DIGIT || r_cnt >= MAX_CNT) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_buf_n = {r_buf[27:0], w_key} & BUF_MASK;
                        w_cnt_n = r_cnt + 4'd1;
                    end
                end
            end
`ifdef KEYPAD_DECIMAL_EN
            // Most significant digit first; the last step writes the result directly
            S_CONVERT: begin
                if (r_idx == 3'd0) begin
                    w_dout_n  = w_acc_mac;
                    w_dv_n    = 1'b1;
                    w_state_n = S_HOLD;
                end else begin
                    w_acc_n = w_acc_mac;
                    w_idx_n = r_idx - 3'd1;
                end
            end
`endif
            S_HOLD: begin
                if (data_ack && r_dv) begin
                    w_dv_n    = 1'b0;
                    w_buf_n   = 32'd0;
                    w_cnt_n   = 4'd0;
                    w_state_n = S_ENTRY;
                end
            end
            default: w_state_n = S_ENTRY;
        endcase
    end

    // Events are only captured in ENTRY, so a key arriving with the ack is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 8'h00;
            r_code <= 8'h00;
            r_evt  <= 1'b0;
            r_buf  <= 32'd0;
            r_cnt  <= 4'd0;
            r_dout <= 32'd0;
            r_dv   <= 1'b0;
            r_err  <= 1'b0;
`ifdef KEYPAD_DECIMAL_EN
            r_acc  <= 32'd0;
            r_idx  <= 3'd0;
`endif
        end else begin
            r_prev <= key_coord;
            r_code <= key_coord;
            r_evt  <= w_event && (r_state == S_ENTRY);
            r_buf  <= w_buf_n;
            r_cnt  <= w_cnt_n;
            r_dout <= w_dout_n;
            r_dv   <= w_dv_n;
            r_err  <= w_err_n;
`ifdef KEYPAD_DECIMAL_EN
            r_acc  <= w_acc_n;
            r_idx  <= w_idx_n;
`endif
        end
    end

    assign disp_value  = r_buf;
    assign disp_digits = r_cnt;
    assign data_out    = r_dout;
    assign data_valid  = r_dv;
    assign key_err     = r_err;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed keypad sequences, a queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_keypad_entry_buffer;
    localparam int MAXD = 8;
`ifdef KEYPAD_DECIMAL_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  key_coord = 8'h00;
    logic        data_ack = 1'b0;
    logic [31:0] disp_value, data_out;
    logic [3:0]  disp_digits;
    logic        data_valid, key_err;

    int vectors = 0;
    int miscompares = 0;
    int n_errp = 0;
    int e0, n;

    keypad_entry_buffer #(.MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord),
        .disp_value(disp_value), .disp_digits(disp_digits),
        .data_out(data_out), .data_valid(data_valid),
        .data_ack(data_ack), .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: key value from the keypad map; -1 = invalid code, 14 = '*', 15 = '#'
    function automatic int keyval(input logic [7:0] c);
        case (c)
            8'h77: return 1;  8'h7B: return 2;  8'h7D: return 3;  8'h7E: return 10;
            8'hB7: return 4;  8'hBB: return 5;  8'hBD: return 6;  8'hBE: return 11;
            8'hD7: return 7;  8'hDB: return 8;  8'hDD: return 9;  8'hDE: return 12;
            8'hE7: return 14; 8'hEB: return 0;  8'hED: return 15; 8'hEE: return 13;
            default: return -1;
        endcase
    endfunction

    int          q[$];
    int          m_phase = 0;   // 0 typing, 1 converting, 2 waiting for ack
    int          m_conv = 0;
    logic [31:0] m_dout = 0;
    bit          m_dv = 0, m_err = 0, m_pend = 0;
    logic [7:0]  m_prev = 0, m_pcode = 0;
    int          ph0, kv;

    function automatic logic [31:0] hexval();
        logic [31:0] v = 0;
        foreach (q[i]) v = (v << 4) | 32'(q[i]);
        return v;
    endfunction

    function automatic logic [31:0] decval();
        logic [31:0] v = 0;
        foreach (q[i]) v = v * 10 + 32'(q[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_phase = 0; m_conv = 0; m_dout = 0; m_dv = 0; m_err = 0;
            m_pend = 0; m_prev = 0; m_pcode = 0;
        end else begin
            ph0 = m_phase;
            m_err = 0;
            if (m_phase == 2) begin
                if (data_ack && m_dv) begin
                    m_dv = 0; q.delete(); m_phase = 0;
                end
            end else if (m_phase == 1) begin
                m_conv--;
                if (m_conv == 0) begin
                    m_dout = decval(); m_dv = 1; m_phase = 2;
                end
            end else if (m_pend) begin
                kv = keyval(m_pcode);
                if (kv < 0 || (DEC && kv > 9 && kv < 14)) m_err = 1;
                else if (kv == 14) begin
                    if (q.size() > 0) void'(q.pop_back());
                end else if (kv == 15) begin
                    if (q.size() > 0) begin
                        if (DEC) begin m_phase = 1; m_conv = q.size(); end
                        else begin m_dout = hexval(); m_dv = 1; m_phase = 2; end
                    end
                end else if (q.size() < MAXD) q.push_back(kv);
                else m_err = 1;
            end
            m_pend  = (key_coord != 0) && (m_prev == 0) && (ph0 == 0);
            m_pcode = key_coord;
            m_prev  = key_coord;
        end
    end

    always @(posedge clk) begin
        #2;
        check("disp_value", disp_value, hexval());
        check("disp_digits", 32'(disp_digits), 32'(q.size()));
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("key_err", 32'(key_err), 32'(m_err));
        if (m_dv) check("data_out", data_out, m_dout);
        if (key_err) n_errp++;
    end

    task automatic tap(input logic [7:0] c);
        @(negedge clk) key_coord = c;
        @(negedge clk) key_coord = 8'h00;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk) rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_disp", disp_value, 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);

        // Reset mid-entry discards the digits
        tap(8'h77); tap(8'h7B);
        check("t1_disp12", disp_value, 32'h12);
        do_reset(2);
        check("t1_rst_disp", disp_value, 32'h0);
        check("t1_rst_cnt", 32'(disp_digits), 32'h0);
        check("t1_rst_dout", data_out, 32'h0);
        check("t1_rst_err", 32'(key_err), 32'h0);
        tap(8'h7D);
        check("t1_disp3", disp_value, 32'h3);
        check("t1_cnt1", 32'(disp_digits), 32'h1);
        tap(8'hE7);

        // Commit, latency to data_valid, HOLD behaviour, ack
        tap(8'h77); tap(8'h7B); tap(DEC ? 8'h7D : 8'h7E);
        @(negedge clk) key_coord = 8'hED;
        @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #2; n++;
            if (data_valid) break;
        end
        check("commit_latency", 32'(n), DEC ? 32'd4 : 32'd1);
        check("commit_dout", data_out, DEC ? 32'd123 : 32'h0000012A);
        @(negedge clk) key_coord = 8'h00;
        repeat (3) @(negedge clk);
        check("hold_valid", 32'(data_valid), 32'h1);
        e0 = n_errp;
        tap(8'h7B);
        check("hold_disp", disp_value, DEC ? 32'h123 : 32'h12A);
        check("hold_noerr", 32'(n_errp - e0), 32'h0);
        @(negedge clk) begin key_coord = 8'h7B; data_ack = 1'b1; end
        @(negedge clk) begin key_coord = 8'h00; data_ack = 1'b0; end
        check("ack_disp", disp_value, 32'h0);
        check("ack_cnt", 32'(disp_digits), 32'h0);
        check("ack_valid", 32'(data_valid), 32'h0);
        repeat (2) @(negedge clk);
        check("ack_key_dropped", 32'(disp_digits), 32'h0);

        // Overflow at MAX_DIGITS
        e0 = n_errp;
        repeat (9) tap(8'hBB);
        check("ovf_disp", disp_value, 32'h55555555);
        check("ovf_cnt", 32'(disp_digits), 32'h8);
        check("ovf_errs", 32'(n_errp - e0), 32'h1);
        do_reset(1);

        // Backspace, including on an empty buffer, and '#' with nothing typed
        e0 = n_errp;
        tap(8'hBB); tap(8'hBD); tap(8'hE7);
        check("bs_disp", disp_value, 32'h5);
        check("bs_cnt", 32'(disp_digits), 32'h1);
        @(negedge clk) data_ack = 1'b1;
        @(negedge clk) data_ack = 1'b0;
        check("stray_ack", 32'(disp_digits), 32'h1);
        tap(8'hE7); tap(8'hE7); tap(8'hED);
        repeat (5) @(negedge clk);
        check("bs_empty_cnt", 32'(disp_digits), 32'h0);
        check("bs_empty_valid", 32'(data_valid), 32'h0);
        check("bs_noerr", 32'(n_errp - e0), 32'h0);

        // Invalid code, held key, nonzero-to-nonzero change
        e0 = n_errp;
        tap(8'h33);
        check("bad_code_err", 32'(n_errp - e0), 32'h1);
        check("bad_code_cnt", 32'(disp_digits), 32'h0);
        @(negedge clk) key_coord = 8'h77;
        repeat (5) @(negedge clk);
        key_coord = 8'h00;
        @(negedge clk);
        check("held_disp", disp_value, 32'h1);
        @(negedge clk) key_coord = 8'h7B;
        repeat (2) @(negedge clk);
        key_coord = 8'hBB;
        repeat (2) @(negedge clk);
        key_coord = 8'h00;
        @(negedge clk);
        check("slide_disp", disp_value, 32'h12);

        e0 = n_errp;
        tap(8'h7E);
        if (DEC) begin
            check("dec_hexkey_err", 32'(n_errp - e0), 32'h1);
            check("dec_hexkey_disp", disp_value, 32'h12);
        end else begin
            check("hex_key_noerr", 32'(n_errp - e0), 32'h0);
            check("hex_key_disp", disp_value, 32'h12A);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end
endmodule
